// File: rtl/gpio_port_pkg.sv
// Shared constants for the GPIO window: address range, register offsets, register select.
// The GPIO_MIN/GPIO_MAX window is also used by the data-side address decoder.
package gpio_port_pkg;

  localparam int GPIO_MIN  = 128;
  localparam int GPIO_MAX  = 130;
  localparam int GPIO_NREG = GPIO_MAX - GPIO_MIN + 1;

  localparam int OFF_OUT  = 0;
  localparam int OFF_DIR  = 1;
  localparam int OFF_STAT = 2;

  typedef enum logic [1:0] {
    SEL_OUT  = 2'(OFF_OUT),
    SEL_DIR  = 2'(OFF_DIR),
    SEL_STAT = 2'(OFF_STAT),
    SEL_NONE = 2'd3
  } reg_sel_e;

  // Offsets past the last register fall back to SEL_NONE.
  function automatic reg_sel_e off_to_sel(input logic hit, input logic [1:0] off);
    if (!hit) return SEL_NONE;
    return reg_sel_e'(off);
  endfunction

endpackage

// File: rtl/gpio_port_if.sv
// Data-bus slot used by the GPIO responder: decoder-gated write strike, address,
// write data and combinational read data back to the CPU read-back mux.
interface gpio_port_if #(parameter int WIDTH = 32);
  logic             we;
  logic [WIDTH-1:0] addr;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] rdata;

  modport master (output we, output addr, output wdata, input rdata);
  modport slave  (input we, input addr, input wdata, output rdata);
endinterface

// File: rtl/gpio_port_sync.sv
// Per-pin 2-flop input synchroniser; with GPIO_IRQ_EN a third flop provides
// a one-cycle rising-edge pulse on the synchronised value.
module gpio_sync #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] i_pins,
`ifdef GPIO_IRQ_EN
  output logic [W-1:0] o_rise,
`endif
  output logic [W-1:0] o_sync
);

  logic [W-1:0] r_s1;
  logic [W-1:0] r_s2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= i_pins;
      r_s2 <= r_s1;
    end
  end

  assign o_sync = r_s2;

`ifdef GPIO_IRQ_EN
  logic [W-1:0] r_s3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_s3 <= '0;
    else        r_s3 <= r_s2;
  end

  assign o_rise = r_s2 & ~r_s3;
`endif

endmodule

// File: rtl/gpio_port.sv
// Memory-mapped GPIO responder: OUT/DIR registers, synchronised inputs, read mux.
// Define GPIO_IRQ_EN to add rising-edge flags with write-1-to-clear and a level irq.
module gpio_port
  import gpio_port_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int GPIO_W = 8,
  parameter int BASE   = GPIO_MIN
) (
  input  logic              clk,
  input  logic              rst_n,
  gpio_port_if.slave        bus,
  input  logic [GPIO_W-1:0] gpio_in,
  output logic [GPIO_W-1:0] gpio_out,
  output logic [GPIO_W-1:0] gpio_oe,
  output logic              irq
);

  logic [GPIO_W-1:0] r_out;
  logic [GPIO_W-1:0] r_dir;
  logic [GPIO_W-1:0] w_in;
  logic [WIDTH-1:0]  w_off;
  logic              w_hit;
  reg_sel_e          w_sel;
  logic              w_unused;

  // Addresses below BASE wrap to a large offset, so one compare covers both sides.
  assign w_off    = bus.addr - WIDTH'(BASE);
  assign w_hit    = (w_off < WIDTH'(GPIO_NREG));
  assign w_sel    = off_to_sel(w_hit, w_off[1:0]);
  assign w_unused = ^bus.wdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out <= '0;
      r_dir <= '0;
    end else if (bus.we) begin
      case (w_sel)
        SEL_OUT: r_out <= bus.wdata[GPIO_W-1:0];
        SEL_DIR: r_dir <= bus.wdata[GPIO_W-1:0];
        default: ;
      endcase
    end
  end

  assign gpio_out = r_out;
  assign gpio_oe  = r_dir;

`ifdef GPIO_IRQ_EN
  logic [GPIO_W-1:0] w_rise;
  logic [GPIO_W-1:0] w_clr;
  logic [GPIO_W-1:0] r_flag;

  gpio_sync #(.W(GPIO_W)) u_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_pins (gpio_in),
    .o_rise (w_rise),
    .o_sync (w_in)
  );

  assign w_clr = (bus.we && w_sel == SEL_STAT) ? bus.wdata[2*GPIO_W-1:GPIO_W] : '0;

  // A new edge in the same cycle as a clear keeps the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_flag <= '0;
    else        r_flag <= (r_flag & ~w_clr) | (w_rise & ~r_dir);
  end

  assign irq = |r_flag;
`else
  gpio_sync #(.W(GPIO_W)) u_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_pins (gpio_in),
    .o_sync (w_in)
  );

  assign irq = 1'b0;
`endif

  always_comb begin
    bus.rdata = '0;
    case (w_sel)
      SEL_OUT:  bus.rdata[GPIO_W-1:0] = r_out;
      SEL_DIR:  bus.rdata[GPIO_W-1:0] = r_dir;
      SEL_STAT: begin
        bus.rdata[GPIO_W-1:0] = w_in;
`ifdef GPIO_IRQ_EN
        bus.rdata[2*GPIO_W-1:GPIO_W] = r_flag;
`endif
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_gpio_port.sv
// Directed self-checking bench for gpio_port (default 8-pin, 32-bit, base 128).
// Flag/irq steps run only when GPIO_IRQ_EN is defined.
module tb_gpio_port;

  localparam int WIDTH  = 32;
  localparam int GPIO_W = 8;

  logic              clk;
  logic              rst_n;
  logic [GPIO_W-1:0] gpio_in;
  logic [GPIO_W-1:0] gpio_out;
  logic [GPIO_W-1:0] gpio_oe;
  logic              irq;
  int                nTests;
  int                nFail;

  gpio_port_if #(.WIDTH(WIDTH)) bus ();

  gpio_port #(.WIDTH(WIDTH), .GPIO_W(GPIO_W), .BASE(128)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .gpio_in  (gpio_in),
    .gpio_out (gpio_out),
    .gpio_oe  (gpio_oe),
    .irq      (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    nTests++;
    assert (observed === expected)
    else begin
      nFail++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // One-cycle write, inputs driven at the falling edge; returns at the next falling edge.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.we    = 1'b1;
    bus.addr  = a;
    bus.wdata = d;
    @(negedge clk);
    bus.we    = 1'b0;
    bus.wdata = '0;
  endtask

  task automatic readCheck(input string tag, input logic [31:0] a, input logic [31:0] expected);
    bus.addr = a;
    #1;
    checkOutput(tag, bus.rdata, expected);
  endtask

  initial begin
    nTests    = 0;
    nFail     = 0;
    rst_n     = 1'b0;
    bus.we    = 1'b0;
    bus.addr  = '0;
    bus.wdata = '0;
    gpio_in   = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    readCheck("rst_rd128", 128, 32'h0);
    readCheck("rst_rd129", 129, 32'h0);
    readCheck("rst_rd130", 130, 32'h0);
    checkOutput("rst_out", 32'(gpio_out), 32'h0);
    checkOutput("rst_oe",  32'(gpio_oe),  32'h0);
    checkOutput("rst_irq", 32'(irq),      32'h0);

    applyStimulus(128, 32'h0000_01A5);
    checkOutput("wr_out", 32'(gpio_out), 32'hA5);
    applyStimulus(129, 32'h0000_00FF);
    checkOutput("wr_oe", 32'(gpio_oe), 32'hFF);
    readCheck("rd_out", 128, 32'hA5);
    readCheck("rd_dir", 129, 32'hFF);

    // Back-to-back writes to OUT on consecutive edges.
    @(negedge clk);
    bus.we = 1'b1; bus.addr = 128; bus.wdata = 32'h11;
    @(negedge clk);
    checkOutput("b2b_first", 32'(gpio_out), 32'h11);
    bus.wdata = 32'h22;
    @(negedge clk);
    bus.we = 1'b0;
    checkOutput("b2b_last", 32'(gpio_out), 32'h22);

    // Input synchroniser latency, DIR=0xFF so no flags appear.
    bus.addr = 130;
    gpio_in  = 8'h3C;
    #1;
    checkOutput("sync_e0", bus.rdata, 32'h0);
    @(negedge clk);
    checkOutput("sync_e1", bus.rdata, 32'h0);
    @(negedge clk);
    checkOutput("sync_e2", bus.rdata, 32'h3C);

    // Out-of-window writes and reads.
    applyStimulus(131, 32'h0000_0000);
    applyStimulus(5,   32'h0000_0000);
    applyStimulus(127, 32'h0000_0000);
    checkOutput("oow_out", 32'(gpio_out), 32'h22);
    checkOutput("oow_oe",  32'(gpio_oe),  32'hFF);
    bus.we = 1'b1; bus.wdata = 32'hFFFF_FFFF;
    readCheck("rd131", 131, 32'h0);
    readCheck("rd127", 127, 32'h0);
    readCheck("rd5",   5,   32'h0);
    bus.we = 1'b0; bus.wdata = '0;

`ifdef GPIO_IRQ_EN
    // Pins 0..3 are inputs, 4..7 outputs: only the low nibble may flag.
    applyStimulus(129, 32'hF0);
    gpio_in = 8'h00;
    repeat (4) @(negedge clk);
    checkOutput("irq_idle", 32'(irq), 32'h0);
    gpio_in = 8'hFF;
    @(negedge clk);
    @(negedge clk);
    checkOutput("irq_e2", 32'(irq), 32'h0);
    @(negedge clk);
    checkOutput("irq_e3", 32'(irq), 32'h1);
    readCheck("flag_rd", 130, 32'h0FFF);
    applyStimulus(130, 32'h0F00);
    checkOutput("w1c_irq", 32'(irq), 32'h0);
    readCheck("w1c_rd", 130, 32'h00FF);

    // Fresh rising edge on pin 0 lands on the same edge as a W1C of bit 8.
    gpio_in = 8'h00;
    repeat (4) @(negedge clk);
    gpio_in = 8'h01;
    @(negedge clk);
    @(negedge clk);
    bus.we = 1'b1; bus.addr = 130; bus.wdata = 32'h100;
    @(negedge clk);
    bus.we = 1'b0; bus.wdata = '0;
    checkOutput("setwin_irq", 32'(irq), 32'h1);
    readCheck("setwin_rd", 130, 32'h0101);
    applyStimulus(130, 32'h100);
    checkOutput("clr_irq", 32'(irq), 32'h0);
    readCheck("clr_rd", 130, 32'h0001);
`else
    // Without the flag logic, rising inputs never raise irq and STAT writes do nothing.
    applyStimulus(129, 32'h00);
    gpio_in = 8'h00;
    repeat (3) @(negedge clk);
    gpio_in = 8'hFF;
    repeat (4) @(negedge clk);
    checkOutput("noirq_irq", 32'(irq), 32'h0);
    applyStimulus(130, 32'hFFFF_FFFF);
    readCheck("noirq_rd", 130, 32'h00FF);
    checkOutput("noirq_out", 32'(gpio_out), 32'h22);
    checkOutput("noirq_oe",  32'(gpio_oe),  32'h00);
`endif

    // Asynchronous reset between clock edges.
    applyStimulus(128, 32'hFF);
    applyStimulus(129, 32'hFF);
    checkOutput("pre_rst_out", 32'(gpio_out), 32'hFF);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("arst_out", 32'(gpio_out), 32'h0);
    checkOutput("arst_oe",  32'(gpio_oe),  32'h0);
    checkOutput("arst_irq", 32'(irq),      32'h0);
    readCheck("arst_rd130", 130, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
